sys_cmd_ctrl: RTL and testbench

//  Generalised system controller between UART RX/TX, register file and ALU.

---
 rtl/sys_cmd_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// System command controller: decodes framed byte commands from UART RX, sequences
// register-file and ALU handshakes, and pushes reply bytes into the TX FIFO.
module sys_cmd_ctrl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ALU_FUNC_WIDTH = 4,
  parameter int                    ADDR_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_WR      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_RD      = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP     = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP    = 8'hDD,
  parameter int                    TIMEOUT        = 255
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       RX_DATA,
  input  logic                        RX_VALID,
  output logic [ADDR_WIDTH-1:0]       RF_ADDR,
  output logic                        RF_WR_EN,
  output logic                        RF_RD_EN,
  output logic [DATA_WIDTH-1:0]       RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]       RF_RD_DATA,
  input  logic                        RF_RD_VALID,
  output logic [ALU_FUNC_WIDTH-1:0]   ALU_FUNC,
  output logic                        ALU_EN,
  output logic                        ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0]     ALU_OUT,
  input  logic                        ALU_OUT_VALID,
  input  logic                        FIFO_FULL,
  output logic                        FIFO_WR,
  output logic [DATA_WIDTH-1:0]       TX_DATA,
  output logic                        BUSY,
  output logic                        CMD_ERR
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, OPA, OPB,
    FUNC, ALU_START, ALU_WAIT, TX_LO, TX_HI, TX_RD
  } state_t;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t                  state;
  logic [WD_W-1:0]         wd_cnt;
  logic [2*DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0]   rd_byte;
  logic                    in_operand;
  logic                    wd_expired;

  // Only the frame-collecting states are guarded by the watchdog; RF/ALU/TX waits are not.
  assign in_operand = state inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUNC};
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));

  // NOTE: every register here is state, so all assignments are non-blocking; mixing in
  // blocking writes would make later reads in this block see same-cycle values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wd_cnt     <= '0;
      alu_res    <= '0;
      rd_byte    <= '0;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      ALU_FUNC   <= '0;
      ALU_EN     <= 1'b0;
      ALU_CLK_EN <= 1'b0;
      FIFO_WR    <= 1'b0;
      TX_DATA    <= '0;
      BUSY       <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly the cycle it is raised for.
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      FIFO_WR  <= 1'b0;
      CMD_ERR  <= 1'b0;

      if (in_operand && !RX_VALID) begin
        if (wd_expired) begin
          state   <= IDLE;
          BUSY    <= 1'b0;
          CMD_ERR <= 1'b1;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (RX_VALID) begin
            case (RX_DATA)
              CMD_RF_WR:   begin state <= WR_ADDR; BUSY <= 1'b1; end
              CMD_RF_RD:   begin state <= RD_ADDR; BUSY <= 1'b1; end
              CMD_ALU_OP:  begin state <= OPA;     BUSY <= 1'b1; end
              CMD_ALU_NOP: begin state <= FUNC;    BUSY <= 1'b1; end
              default:     CMD_ERR <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (RX_VALID) begin
            RF_ADDR <= RX_DATA[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_VALID) begin
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= WR_EXEC;
          end
        end
        WR_EXEC: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        RD_ADDR: begin
          if (RX_VALID) begin
            RF_ADDR  <= RX_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            state    <= RD_REQ;
          end
        end
        RD_REQ:  state <= RD_WAIT;
        RD_WAIT: begin
          if (RF_RD_VALID) begin
            rd_byte <= RF_RD_DATA;
            state   <= TX_RD;
          end
        end
        OPA: begin
          if (RX_VALID) begin
            RF_ADDR    <= '0;
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= OPB;
          end
        end
        OPB: begin
          if (RX_VALID) begin
            RF_ADDR    <= ADDR_WIDTH'(1);
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= FUNC;
          end
        end
        FUNC: begin
          if (RX_VALID) begin
            ALU_FUNC   <= RX_DATA[ALU_FUNC_WIDTH-1:0];
            ALU_EN     <= 1'b1;
            ALU_CLK_EN <= 1'b1;
            state      <= ALU_START;
          end
        end
        ALU_START: state <= ALU_WAIT;
        ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            alu_res    <= ALU_OUT;
            ALU_CLK_EN <= 1'b0;
            state      <= TX_LO;
          end
        end
        TX_LO: begin
          if (!FIFO_FULL) begin
            FIFO_WR <= 1'b1;
            TX_DATA <= alu_res[DATA_WIDTH-1:0];
            state   <= TX_HI;
          end
        end
        TX_HI: begin
          if (!FIFO_FULL) begin
            FIFO_WR  <= 1'b1;
            TX_DATA  <= alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
            ALU_FUNC <= '0;
            state    <= IDLE;
            BUSY     <= 1'b0;
          end
        end
        TX_RD: begin
          if (!FIFO_FULL) begin
            FIFO_WR <= 1'b1;
            TX_DATA <= rd_byte;
            state   <= IDLE;
            BUSY    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: stimulus pushes expected RF/ALU/TX/error events,
// a negedge monitor pops and compares them as the controller produces them.
`timescale 1ns/1ps
module tb_sys_cmd_ctrl;
  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN, RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = '0;
  logic [3:0]  ALU_FUNC;
  logic        ALU_EN, ALU_CLK_EN;
  logic [15:0] ALU_OUT = '0;
  logic        FIFO_FULL = 1'b0;
  logic        FIFO_WR;
  logic [7:0]  TX_DATA;
  logic        BUSY, CMD_ERR;

  logic rd_vld_rsp = 1'b0, rd_vld_spur = 1'b0;
  logic alu_vld_rsp = 1'b0, alu_vld_spur = 1'b0;
  logic full_q = 1'b0;

  int checks = 0, errors = 0;
  int err_issued = 0, err_seen = 0;
  int rd_lat = 3, alu_lat = 2, full_force = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  ref_rf[16];
  logic [7:0]  rf_mem[16];

  sys_cmd_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA),
    .RF_RD_VALID(rd_vld_rsp | rd_vld_spur), .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN),
    .ALU_CLK_EN(ALU_CLK_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(alu_vld_rsp | alu_vld_spur),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR(FIFO_WR), .TX_DATA(TX_DATA), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ALU behaviour assumed by this environment, selected by function code.
  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {a, b};
      4'd3:    return a * b;
      4'd4:    return {8'h00, a & b};
      4'd5:    return {8'h00, a | b};
      4'd6:    return {8'h00, a ^ b};
      default: return {b, a};
    endcase
  endfunction

  // Register file and ALU models driven by the controller's strobes.
  always @(posedge CLK) begin
    full_q <= FIFO_FULL;
    if (RF_WR_EN) rf_mem[RF_ADDR] <= RF_WR_DATA;
  end

  initial begin : rf_rd_responder
    logic [3:0] a;
    forever begin
      @(negedge CLK);
      if (RF_RD_EN) begin
        a = RF_ADDR;
        repeat (rd_lat) @(negedge CLK);
        RF_RD_DATA = rf_mem[a];
        rd_vld_rsp = 1'b1;
        @(negedge CLK);
        rd_vld_rsp = 1'b0;
      end
    end
  end

  initial begin : alu_responder
    logic [3:0] f;
    logic [7:0] a, b;
    forever begin
      @(negedge CLK);
      if (ALU_EN) begin
        f = ALU_FUNC; a = rf_mem[0]; b = rf_mem[1];
        repeat (alu_lat) @(negedge CLK);
        ALU_OUT = alu_fn(f, a, b);
        alu_vld_rsp = 1'b1;
        @(negedge CLK);
        alu_vld_rsp = 1'b0;
      end
    end
  end

  initial begin : fifo_full_driver
    forever begin
      @(negedge CLK);
      FIFO_FULL = (full_force < 0) ? ($urandom_range(0, 2) == 0) : full_force[0];
    end
  end

  initial begin : monitor
    logic [11:0] ew;
    int n;
    forever begin
      @(negedge CLK);
      n = $countones({RF_WR_EN, RF_RD_EN, ALU_EN, FIFO_WR});
      if (n > 0) check("strobe_onehot", n, 1);
      if (RF_WR_EN) begin
        check("rf_wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          check("rf_wr_addr", RF_ADDR, ew[11:8]);
          check("rf_wr_data", RF_WR_DATA, ew[7:0]);
        end
      end
      if (RF_RD_EN) begin
        check("rf_rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rf_rd_addr", RF_ADDR, exp_rd.pop_front());
      end
      if (ALU_EN) begin
        check("alu_en_expected", exp_alu.size() != 0, 1);
        check("alu_clk_en_on_start", ALU_CLK_EN, 1);
        if (exp_alu.size() != 0) check("alu_func", ALU_FUNC, exp_alu.pop_front());
      end
      if (FIFO_WR) begin
        check("fifo_wr_while_not_full", full_q, 0);
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) check("tx_data", TX_DATA, exp_tx.pop_front());
      end
      if (CMD_ERR) begin
        check("cmd_err_expected", err_seen < err_issued, 1);
        err_seen++;
      end
    end
  end

  initial begin : global_timeout
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Called at a negedge: RX_VALID high for one cycle, then 'idle' quiet cycles.
  task automatic send_byte(input logic [7:0] b, input int idle);
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
    repeat (idle) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY === 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_reached", BUSY, 0);
  endtask

  function automatic int gp();
    return $urandom_range(0, 3);
  endfunction

  task automatic cmd_wr(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a[3:0], d});
    ref_rf[a[3:0]] = d;
    send_byte(8'hAA, gp()); send_byte(a, gp()); send_byte(d, 0);
    wait_idle();
  endtask

  task automatic cmd_rd(input logic [7:0] a);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(ref_rf[a[3:0]]);
    send_byte(8'hBB, gp()); send_byte(a, 0);
    wait_idle();
  endtask

  task automatic cmd_alu(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f);
    logic [15:0] r;
    exp_wr.push_back({4'h0, x});
    exp_wr.push_back({4'h1, y});
    ref_rf[0] = x; ref_rf[1] = y;
    exp_alu.push_back(f[3:0]);
    r = alu_fn(f[3:0], x, y);
    exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
    send_byte(8'hCC, gp()); send_byte(x, gp()); send_byte(y, gp()); send_byte(f, 0);
    wait_idle();
  endtask

  task automatic cmd_nop(input logic [7:0] f);
    logic [15:0] r;
    exp_alu.push_back(f[3:0]);
    r = alu_fn(f[3:0], ref_rf[0], ref_rf[1]);
    exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
    send_byte(8'hDD, gp()); send_byte(f, 0);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUNC, ALU_EN, ALU_CLK_EN,
                 FIFO_WR, TX_DATA, BUSY, CMD_ERR}, 0);
  endtask

  initial begin : stimulus
    logic [7:0] b;
    int n;
    for (int i = 0; i < 16; i++) begin ref_rf[i] = '0; rf_mem[i] = '0; end
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_outputs");
    RST = 1'b0;
    @(negedge CLK);

    // T1..T3 directed
    cmd_wr(8'h05, 8'h3C);
    rd_lat = 3;
    cmd_wr(8'h02, 8'h7E);
    cmd_rd(8'h02);
    cmd_alu(8'h10, 8'h20, 8'h00);

    // T4: result held while the TX FIFO is full, then bytes leave low first
    cmd_wr(8'h00, 8'hAB);
    cmd_wr(8'h01, 8'hCD);
    full_force = 1;
    @(negedge CLK);
    exp_alu.push_back(4'h2);
    exp_tx.push_back(8'hCD); exp_tx.push_back(8'hAB);
    send_byte(8'hDD, 0); send_byte(8'h02, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("t4_no_push_while_full", FIFO_WR, 0);
    end
    full_force = 0;
    wait_idle();

    // T5: unknown command, then watchdog boundary
    err_issued++;
    send_byte(8'h55, 0);
    for (int k = 0; k < 3; k++) begin
      check("unknown_cmd_busy_low", BUSY, 0);
      @(negedge CLK);
    end
    exp_wr.push_back({4'h9, 8'h5A});
    ref_rf[9] = 8'h5A;
    send_byte(8'hAA, TO); send_byte(8'h19, TO); send_byte(8'h5A, 0);
    wait_idle();
    err_issued++;
    send_byte(8'hAA, 0); send_byte(8'h05, TO);
    check("wd_not_early", BUSY, 1);
    @(negedge CLK);
    check("wd_abort_idle", BUSY, 0);
    repeat (5) @(negedge CLK);
    cmd_rd(8'h05);

    // T6: reset while waiting for the ALU; the late result must not be sent
    alu_lat = 15;
    exp_alu.push_back(4'h1);
    send_byte(8'hDD, 0); send_byte(8'h01, 0);
    n = 0;
    while (exp_alu.size() != 0 && n < 100) begin @(negedge CLK); n++; end
    check("t6_alu_started", exp_alu.size(), 0);
    repeat (3) @(negedge CLK);
    check("t6_in_alu_wait", ALU_CLK_EN, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("t6_reset_outputs");
    RST = 1'b0;
    repeat (25) @(negedge CLK);
    check("t6_idle_after_late_valid", BUSY, 0);
    alu_lat = 2;

    // Randomized traffic
    full_force = -1;
    repeat (150) begin
      rd_lat = $urandom_range(1, 5);
      alu_lat = $urandom_range(1, 5);
      case ($urandom_range(0, 9))
        0, 1, 2: cmd_wr(8'($urandom), 8'($urandom));
        3, 4:    cmd_rd(8'($urandom));
        5, 6:    cmd_alu(8'($urandom), 8'($urandom), 8'($urandom));
        7, 8:    cmd_nop(8'($urandom));
        default: begin
          do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
          err_issued++;
          send_byte(b, 1);
        end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        alu_vld_spur = 1'b1; rd_vld_spur = 1'b1;
        @(negedge CLK);
        alu_vld_spur = 1'b0; rd_vld_spur = 1'b0;
        @(negedge CLK);
      end
    end

    full_force = 0;
    repeat (10) @(negedge CLK);
    check("wr_drained", exp_wr.size(), 0);
    check("rd_drained", exp_rd.size(), 0);
    check("alu_drained", exp_alu.size(), 0);
    check("tx_drained", exp_tx.size(), 0);
    check("cmd_err_count", err_seen, err_issued);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
